// File: rtl/lcd_framebuffer.sv
// 240x64 LCD bitmap store: free-running registered read port, host write port, full-screen clear engine.
// Optional FB_INVERT_EN adds an invert input that complements the pixels output.
module lcd_framebuffer #(
    parameter int unsigned MAX_X = 240,
    parameter int unsigned PAGES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  x,
    input  logic [3:0]  y,
    output logic [7:0]  pixels,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [10:0] wr_addr,
    input  logic [7:0]  wr_data,
    input  logic        clear_req,
    input  logic [7:0]  fill_value,
`ifdef FB_INVERT_EN
    input  logic        invert,
`endif
    output logic        busy
);

    localparam logic [7:0] LAST_COL  = 8'(MAX_X - 1);
    localparam logic [2:0] LAST_PAGE = 3'(PAGES - 1);

    typedef enum logic {IDLE, FILL} state_t;

    state_t      state;
    logic [2:0]  page;
    logic [7:0]  col;
    logic [7:0]  fill_byte;

    logic [7:0]  mem [0:2047];
    logic        we;
    logic [10:0] waddr;
    logic [7:0]  wdata;
    logic [7:0]  rd_byte;

    assign wr_ready = !busy && !reset;

    // Fill writes are gated by reset so an abort leaves exactly the cells already written.
    always_comb begin
        we    = 1'b0;
        waddr = wr_addr;
        wdata = wr_data;
        if (state == FILL) begin
            we    = !reset;
            waddr = {page, col};
            wdata = fill_byte;
        end else if (wr_valid && wr_ready && (wr_addr[7:0] <= LAST_COL)) begin
            we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rd_byte = mem[{y[2:0], x}];

    always_ff @(posedge clk) begin
        if (reset) begin
            pixels <= '0;
        end else begin
`ifdef FB_INVERT_EN
            pixels <= invert ? ~rd_byte : rd_byte;
`else
            pixels <= rd_byte;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            page  <= '0;
            col   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear_req) begin
                        fill_byte <= fill_value;
                        page      <= '0;
                        col       <= '0;
                        busy      <= 1'b1;
                        state     <= FILL;
                    end
                end
                FILL: begin
                    if (col == LAST_COL) begin
                        col <= '0;
                        if (page == LAST_PAGE) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            page <= page + 3'd1;
                        end
                    end else begin
                        col <= col + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_framebuffer.sv
// Directed self-checking bench for lcd_framebuffer: reset, host writes, dropped columns,
// clear engine timing/content, read-first collision, reset abort, optional invert.
module tb_lcd_framebuffer;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  x;
    logic [3:0]  y;
    logic [7:0]  pixels;
    logic        wr_valid;
    logic        wr_ready;
    logic [10:0] wr_addr;
    logic [7:0]  wr_data;
    logic        clear_req;
    logic [7:0]  fill_value;
    logic        busy;
`ifdef FB_INVERT_EN
    logic        invert;
`endif

    int unsigned checks = 0;
    int unsigned errors = 0;

    lcd_framebuffer #(.MAX_X(240), .PAGES(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .x          (x),
        .y          (y),
        .pixels     (pixels),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .clear_req  (clear_req),
        .fill_value (fill_value),
`ifdef FB_INVERT_EN
        .invert     (invert),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [2:0] pg, input logic [7:0] cl, input logic [7:0] d);
        wr_valid = 1'b1;
        wr_addr  = {pg, cl};
        wr_data  = d;
        check("wr_ready_before_write", {31'd0, wr_ready}, 32'd1);
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic read_at(input logic [3:0] yy, input logic [7:0] xx, output logic [7:0] d);
        y = yy;
        x = xx;
        tick();
        d = pixels;
    endtask

    logic [7:0]  rd;
    int unsigned n;
    int unsigned ready_seen;
    int unsigned bad_reads;
    logic [7:0]  exp_b;

    initial begin
        reset = 1'b1; x = '0; y = '0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        clear_req = 1'b0; fill_value = '0;
`ifdef FB_INVERT_EN
        invert = 1'b0;
`endif
        // 1. reset state
        repeat (3) tick();
        check("reset_pixels", {24'd0, pixels}, 32'h00);
        check("reset_wr_ready", {31'd0, wr_ready}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        #1;
        check("ready_after_reset", {31'd0, wr_ready}, 32'd1);

        // 4. full clear with 0xFF; second clear_req mid-fill with a different value must be ignored
        fill_value = 8'hFF;
        clear_req  = 1'b1;
        tick();
        clear_req  = 1'b0;
        fill_value = 8'h11;
        n = 0;
        ready_seen = 0;
        while (busy && n < 4000) begin
            n++;
            if (wr_ready) ready_seen++;
            clear_req = (n == 500);
            tick();
        end
        clear_req = 1'b0;
        check("clear_busy_cycles", n, 32'd1920);
        check("clear_ready_low", ready_seen, 32'd0);
        check("ready_after_clear", {31'd0, wr_ready}, 32'd1);
        bad_reads = 0;
        for (int p = 0; p < 8; p++) begin
            for (int c = 0; c < 240; c++) begin
                read_at(4'(p), 8'(c), rd);
                if (rd !== 8'hFF) bad_reads++;
            end
        end
        check("clear_all_ff", bad_reads, 32'd0);

        // 2. host write and read, y[3] ignored
        host_write(3'd3, 8'd17, 8'hA5);
        read_at(4'd3, 8'd17, rd);
        check("read_3_17", {24'd0, rd}, 32'hA5);
        read_at(4'hB, 8'd17, rd);
        check("read_y_B_17", {24'd0, rd}, 32'hA5);

        // 3. write to column 240 is dropped
        host_write(3'd0, 8'd240, 8'h5A);
        bad_reads = 0;
        for (int p = 0; p < 8; p++) begin
            for (int c = 0; c < 240; c++) begin
                exp_b = (p == 3 && c == 17) ? 8'hA5 : 8'hFF;
                read_at(4'(p), 8'(c), rd);
                if (rd !== exp_b) bad_reads++;
            end
        end
        check("col240_dropped", bad_reads, 32'd0);

        // 5. same-cycle read and write is read-first
        host_write(3'd2, 8'd5, 8'h00);
        y = 4'd2; x = 8'd5;
        wr_valid = 1'b1; wr_addr = {3'd2, 8'd5}; wr_data = 8'h3C;
        tick();
        wr_valid = 1'b0;
        check("collision_old", {24'd0, pixels}, 32'h00);
        tick();
        check("collision_new", {24'd0, pixels}, 32'h3C);

        // 6. reset 100 cycles into a clear aborts it
        fill_value = 8'h00;
        clear_req  = 1'b1;
        tick();
        clear_req  = 1'b0;
        repeat (100) tick();
        check("busy_before_abort", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("ready_low_in_reset", {31'd0, wr_ready}, 32'd0);
        tick();
        check("busy_after_abort", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        read_at(4'd0, 8'd0, rd);
        check("abort_col0", {24'd0, rd}, 32'h00);
        read_at(4'd0, 8'd99, rd);
        check("abort_col99", {24'd0, rd}, 32'h00);
        read_at(4'd0, 8'd100, rd);
        check("abort_col100", {24'd0, rd}, 32'hFF);
        read_at(4'd3, 8'd17, rd);
        check("abort_untouched", {24'd0, rd}, 32'hA5);

        // clear_req with a same-cycle host write: the fill overwrites it
        wr_valid = 1'b1; wr_addr = {3'd1, 8'd7}; wr_data = 8'h77;
        fill_value = 8'h42; clear_req = 1'b1;
        check("ready_with_clear_req", {31'd0, wr_ready}, 32'd1);
        tick();
        wr_valid = 1'b0; clear_req = 1'b0;
        n = 0;
        while (busy && n < 4000) begin
            n++;
            tick();
        end
        check("second_clear_cycles", n, 32'd1920);
        read_at(4'd1, 8'd7, rd);
        check("fill_overwrites_write", {24'd0, rd}, 32'h42);

`ifdef FB_INVERT_EN
        // 7. invert path
        host_write(3'd1, 8'd1, 8'h0F);
        y = 4'd1; x = 8'd1; invert = 1'b1;
        tick();
        check("invert_on", {24'd0, pixels}, 32'hF0);
        invert = 1'b0;
        tick();
        check("invert_off", {24'd0, pixels}, 32'h0F);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
